sr_shift_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for a shared left-shift serial lane. Each requester presents a parallel word. The block grants one requester, loads its word into an internal left-shift register, and shifts it out MSB-first on `so` for WIDTH cycles. It then enforces an inter-frame gap before arbitrating again. It sits between parallel-word producers and a single serial output line.

---
 rtl/sr_shift_arbiter_if.sv | 27 ++
 rtl/sr_shift_arbiter.sv | 112 +++++++++++
 tb/tb_sr_shift_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_shift_arbiter_if.sv
// Bus between parallel-word requesters (master side) and the serial-lane arbiter (slave side).
// WIDTH must match the WIDTH of the sr_shift_arbiter bound to this interface.
interface sr_shift_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             ack0;
  logic             ack1;
  logic             so;
  logic             so_valid;
  logic             so_owner;
  logic             so_last;
  logic             busy;

  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, so, so_valid, so_owner, so_last, busy
  );

  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, so, so_valid, so_owner, so_last, busy
  );
endinterface

// File: rtl/sr_shift_arbiter.sv
// Two-requester round-robin arbiter feeding one MSB-first serial lane,
// with a fixed inter-frame gap after every frame.
module sr_shift_arbiter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  sr_shift_arbiter_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gap;
  logic             r_rr;
  logic             r_owner;
  logic             r_ack0;
  logic             r_ack1;

  logic [WIDTH-1:0] w_sr_shl;
  logic             w_gnt_valid;
  logic             w_gnt_idx;

  // A one-bit frame has nothing left to shift in; avoid the empty slice.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sr_shl = '0;
    end else begin : g_wn
      assign w_sr_shl = {r_sr[WIDTH-2:0], 1'b0};
    end
  endgenerate

  always_comb begin
    w_gnt_valid = bus.req0 | bus.req1;
    w_gnt_idx   = (bus.req0 && bus.req1) ? ~r_rr : bus.req1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_rr    <= 1'b1;
      r_owner <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_sr    <= w_gnt_idx ? bus.data1 : bus.data0;
            r_cnt   <= '0;
            r_rr    <= w_gnt_idx;
            r_owner <= w_gnt_idx;
            r_ack0  <= ~w_gnt_idx;
            r_ack1  <= w_gnt_idx;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sr  <= w_sr_shl;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_gap <= '0;
            if (GAP > 0) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
              r_owner <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_owner <= 1'b0;
        end
      endcase
    end
  end

  // sr is all-zero outside SHIFT, so so needs no extra gating.
  assign bus.so       = r_sr[WIDTH-1];
  assign bus.so_valid = (r_state == S_SHIFT);
  assign bus.so_last  = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
  assign bus.so_owner = r_owner;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
endmodule

// File: tb/tb_sr_shift_arbiter.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor rebuilds
// each serial frame and checks it against the queue (two DUT configurations).
module tb_sr_shift_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  sr_shift_arbiter_if #(.WIDTH(8)) ifa ();
  sr_shift_arbiter_if #(.WIDTH(4)) ifb ();

  sr_shift_arbiter #(.WIDTH(8), .GAP(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  sr_shift_arbiter #(.WIDTH(4), .GAP(0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  typedef struct {
    int owner;
    int data;
    int delta;
  } frame_t;

  frame_t qa[$];
  frame_t qb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit done_a  = 0;
  bit done_b  = 0;

  int bit_i[2];
  int word[2];
  int own_f[2];
  int cur_start[2];
  int last_start[2];

  logic [7:0] d0[2];
  logic [7:0] d1[2];
  int i0;
  int i1;
  bit got;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push(input int m, input int o, input int d, input int dl);
    frame_t f;
    f.owner = o;
    f.data  = d;
    f.delta = dl;
    if (m == 0) qa.push_back(f);
    else qb.push_back(f);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input int m, input int which, input int lim, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      step(1);
      if (m == 0) seen = (which != 0) ? ifa.ack1 : ifa.ack0;
      else seen = (which != 0) ? ifb.ack1 : ifb.ack0;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic wait_empty(input int m, input int lim, input string name);
    int sz;
    sz = (m == 0) ? qa.size() : qb.size();
    for (int i = 0; i < lim && sz != 0; i++) begin
      step(1);
      sz = (m == 0) ? qa.size() : qb.size();
    end
    chk(name, sz, 0);
  endtask

  task automatic mon_step(input int m, input int w, input logic r, input logic s,
                          input logic vld, input logic own, input logic last,
                          input logic a0, input logic a1, input logic bsy);
    frame_t e;
    bit have;
    if (r) begin
      bit_i[m]      = 0;
      word[m]       = 0;
      last_start[m] = -1;
      return;
    end
    if (vld) begin
      if (bit_i[m] == 0) begin
        own_f[m]     = int'(own);
        cur_start[m] = cyc;
        chk("ack_at_first_bit", int'({a0, a1}), own ? 1 : 2);
      end else begin
        chk("ack_mid_frame", int'({a0, a1}), 0);
        chk("owner_stable", int'(own), own_f[m]);
      end
      chk("so_last", int'(last), int'(bit_i[m] == w - 1));
      chk("busy_in_frame", int'(bsy), 1);
      word[m] = (word[m] << 1) | int'(s);
      bit_i[m]++;
      if (bit_i[m] == w) begin
        bit_i[m] = 0;
        have = (m == 0) ? (qa.size() != 0) : (qb.size() != 0);
        if (!have) begin
          chk("unexpected_frame", word[m], -1);
        end else begin
          if (m == 0) e = qa.pop_front();
          else e = qb.pop_front();
          chk("frame_data", word[m], e.data);
          chk("frame_owner", own_f[m], e.owner);
          if (e.delta >= 0) chk("frame_spacing", cur_start[m] - last_start[m], e.delta);
        end
        last_start[m] = cur_start[m];
        word[m] = 0;
      end
    end else begin
      chk("idle_so", int'(s), 0);
      chk("idle_last", int'(last), 0);
      chk("idle_ack", int'({a0, a1}), 0);
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, 8, rst_a, ifa.so, ifa.so_valid, ifa.so_owner, ifa.so_last, ifa.ack0, ifa.ack1, ifa.busy);
    mon_step(1, 4, rst_b, ifb.so, ifb.so_valid, ifb.so_owner, ifb.so_last, ifb.ack0, ifb.ack1, ifb.busy);
  end

  // WIDTH=8, GAP=1 sequences
  initial begin
    d0[0] = 8'hA1; d0[1] = 8'h3E;
    d1[0] = 8'h5C; d1[1] = 8'hC7;
    rst_a = 1'b1;
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.data0 = '0; ifa.data1 = '0;
    step(2);
    chk("a_reset_outputs", int'({ifa.so, ifa.so_valid, ifa.so_owner, ifa.so_last,
                                 ifa.ack0, ifa.ack1, ifa.busy}), 0);
    rst_a = 1'b0;

    // single request, one-cycle latency, gap then idle
    push(0, 0, 'hB2, -1);
    ifa.data0 = 8'hB2; ifa.req0 = 1'b1;
    wait_ack(0, 0, 1, "t1_ack0_latency");
    ifa.req0 = 1'b0;
    chk("t1_first_bit_valid", int'(ifa.so_valid), 1);
    step(8);
    chk("t1_gap_busy", int'(ifa.busy), 1);
    chk("t1_gap_valid", int'(ifa.so_valid), 0);
    step(1);
    chk("t1_idle_busy", int'(ifa.busy), 0);
    wait_empty(0, 20, "t1_done");

    // simultaneous requests after reset: req0 first, req1 ten cycles later
    rst_a = 1'b1; step(1); rst_a = 1'b0;
    push(0, 0, 'hFF, -1);
    push(0, 1, 'h0F, 10);
    ifa.data0 = 8'hFF; ifa.data1 = 8'h0F; ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    wait_ack(0, 0, 1, "t2_ack0");
    ifa.req0 = 1'b0;
    wait_ack(0, 1, 12, "t2_ack1");
    ifa.req1 = 1'b0;
    wait_empty(0, 20, "t2_done");

    // both held high: owners alternate with constant spacing
    rst_a = 1'b1; step(1); rst_a = 1'b0;
    push(0, 0, 'hA1, -1);
    push(0, 1, 'h5C, 10);
    push(0, 0, 'h3E, 10);
    push(0, 1, 'hC7, 10);
    i0 = 0; i1 = 0;
    ifa.data0 = d0[0]; ifa.data1 = d1[0]; ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int t = 0; t < 15 && !got; t++) begin
        step(1);
        if (ifa.ack0) begin
          got = 1; i0++;
          ifa.data0 = (i0 < 2) ? d0[i0] : 8'h00;
        end else if (ifa.ack1) begin
          got = 1; i1++;
          ifa.data1 = (i1 < 2) ? d1[i1] : 8'h00;
        end
      end
      chk("t3_grant", int'(got), 1);
    end
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    wait_empty(0, 20, "t3_done");

    // reset during bit 4 drops the frame; tie afterwards goes to req0
    rst_a = 1'b1; step(1); rst_a = 1'b0;
    ifa.data0 = 8'h96; ifa.req0 = 1'b1;
    wait_ack(0, 0, 1, "t4_ack0");
    ifa.req0 = 1'b0;
    step(3);
    chk("t4_bit4_valid", int'(ifa.so_valid), 1);
    rst_a = 1'b1;
    step(1);
    chk("t4_reset_outputs", int'({ifa.so, ifa.so_valid, ifa.busy, ifa.ack0, ifa.ack1,
                                  ifa.so_last, ifa.so_owner}), 0);
    rst_a = 1'b0;
    push(0, 0, 'h55, -1);
    push(0, 1, 'hAA, 10);
    ifa.data0 = 8'h55; ifa.data1 = 8'hAA; ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    wait_ack(0, 0, 1, "t4_tie_ack0");
    ifa.req0 = 1'b0;
    wait_ack(0, 1, 12, "t4_ack1");
    ifa.req1 = 1'b0;
    wait_empty(0, 20, "t4_done");
    step(3);

    // short req1 pulse inside a req0 frame is ignored
    push(0, 0, 'h3C, -1);
    ifa.data0 = 8'h3C; ifa.req0 = 1'b1;
    wait_ack(0, 0, 1, "t6_ack0");
    ifa.req0 = 1'b0;
    step(1);
    ifa.data1 = 8'hEE; ifa.req1 = 1'b1;
    step(3);
    ifa.req1 = 1'b0;
    step(5);
    chk("t6_idle_busy", int'(ifa.busy), 0);
    step(12);
    chk("t6_still_idle", int'(ifa.busy), 0);
    wait_empty(0, 5, "t6_done");
    done_a = 1;
  end

  // WIDTH=4, GAP=0 sequence
  initial begin
    rst_b = 1'b1;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.data0 = '0; ifb.data1 = '0;
    step(2);
    chk("b_reset_outputs", int'({ifb.so, ifb.so_valid, ifb.so_owner, ifb.so_last,
                                 ifb.ack0, ifb.ack1, ifb.busy}), 0);
    rst_b = 1'b0;
    push(1, 1, 'hA, -1);
    push(1, 1, 'h5, 5);
    ifb.data1 = 4'hA; ifb.req1 = 1'b1;
    wait_ack(1, 1, 1, "b_ack1_first");
    ifb.data1 = 4'h5;
    wait_ack(1, 1, 6, "b_ack1_second");
    ifb.req1 = 1'b0;
    wait_empty(1, 20, "b_done");
    done_b = 1;
  end

  initial begin
    for (int i = 0; i < 5000 && !(done_a && done_b); i++) @(posedge clk);
    chk("all_sequences_complete", int'(done_a && done_b), 1);
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
